// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types, display codes and sentinel helpers for bcd_to_binary.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam logic [3:0] DIGIT_DASH  = 4'b1010;
    localparam logic [3:0] DIGIT_BLANK = 4'b1011;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PATH_NUM   = 2'd0,
        PATH_DASH  = 2'd1,
        PATH_BLANK = 2'd2,
        PATH_ERR   = 2'd3
    } path_t;

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    // Sentinels are returned 32 bits wide; callers cast down to their width.
    function automatic logic [31:0] sentinel_dash(input int bin_w);
        return 32'hFFFF_FFFF >> (32 - bin_w);
    endfunction

    function automatic logic [31:0] sentinel_blank(input int bin_w);
        return (32'hFFFF_FFFF >> (32 - bin_w)) - 32'd1;
    endfunction

    function automatic path_t classify(
        input logic [3:0] h,
        input logic [3:0] t,
        input logic [3:0] o
    );
        path_t p;
        if (h == DIGIT_DASH && t == DIGIT_DASH && o == DIGIT_DASH)
            p = PATH_DASH;
        else if (h == DIGIT_BLANK && t == DIGIT_BLANK && o == DIGIT_BLANK)
            p = PATH_BLANK;
        else if (h > DIGIT_MAX || t > DIGIT_MAX || o > DIGIT_MAX)
            p = PATH_ERR;
        else
            p = PATH_NUM;
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module  : bcd_digit_adjust
// Brief   : Reverse double-dabble digit correction: subtract 3 when digit >= 8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd8)
            o_digit = i_digit - 4'd3;
    end

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary.sv
// ============================================================================
// Module  : bcd_to_binary
// Brief   : Sequential 3-digit BCD to binary converter (reverse double-dabble)
//           with dash/blank sentinel recognition and start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int BIN_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       hundreds_in,
    input  logic [3:0]       tens_in,
    input  logic [3:0]       ones_in,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] binary,
    output logic             error,
    output logic             special
);

    localparam int                 c_cnt_w      = cnt_width(BIN_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(BIN_W);
    localparam logic [BIN_W-1:0]   c_sent_dash  = BIN_W'(sentinel_dash(BIN_W));
    localparam logic [BIN_W-1:0]   c_sent_blank = BIN_W'(sentinel_blank(BIN_W));

    state_t             r_state;
    path_t              r_path;
    logic [11:0]        r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [c_cnt_w-1:0] r_cnt;

    logic [BIN_W+11:0]  w_cat_sh;
    logic [11:0]        w_bcd_sh;
    logic [11:0]        w_bcd_adj;
    logic [BIN_W-1:0]   w_bin_sh;

    assign w_cat_sh = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_cat_sh[BIN_W+11:BIN_W];
    assign w_bin_sh = w_cat_sh[BIN_W-1:0];

    // Each digit is corrected independently; no borrow crosses digit lanes.
    for (genvar g_i = 0; g_i < 3; g_i++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .i_digit (w_bcd_sh[g_i*4 +: 4]),
            .o_digit (w_bcd_adj[g_i*4 +: 4])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_path  <= PATH_NUM;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            binary  <= '0;
            error   <= 1'b0;
            special <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_bcd   <= {hundreds_in, tens_in, ones_in};
                        r_bin   <= '0;
                        r_cnt   <= '0;
                        r_path  <= classify(hundreds_in, tens_in, ones_in);
                        busy    <= 1'b1;
                        binary  <= '0;
                        error   <= 1'b0;
                        special <= 1'b0;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Sentinel and error paths still run all steps so latency is fixed.
                    if (r_cnt == c_cnt_last) begin
                        done    <= 1'b1;
                        r_state <= DONE;
                        case (r_path)
                            PATH_NUM: begin
                                if (|r_bcd) begin
                                    binary <= '0;
                                    error  <= 1'b1;
                                end else begin
                                    binary <= r_bin;
                                    error  <= 1'b0;
                                end
                                special <= 1'b0;
                            end
                            PATH_DASH: begin
                                binary  <= c_sent_dash;
                                error   <= 1'b0;
                                special <= 1'b1;
                            end
                            PATH_BLANK: begin
                                binary  <= c_sent_blank;
                                error   <= 1'b0;
                                special <= 1'b1;
                            end
                            default: begin
                                binary  <= '0;
                                error   <= 1'b1;
                                special <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_bcd <= w_bcd_adj;
                        r_bin <= w_bin_sh;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential BCD-to-binary converter: the inverse of the display-side binary-to-BCD block. Converts a 3-digit BCD value (hundreds/tens/ones) back to a BIN_W-bit unsigned binary value.
- Algorithm: reverse double-dabble, one shift per clock.
- Display codes are recognised and mapped back to their binary sentinels: dash (4'b1010 on all digits) → all-ones; blank (4'b1011 on all digits) → all-ones minus 1.
- Sits between the keypad/display digit path and the CPU datapath; start/done handshake.

Parameters:
- BIN_W, 7: output width; also the number of shift iterations.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- hundreds_in  input  4  BCD hundreds digit or display code
- tens_in  input  4  BCD tens digit or display code
- ones_in  input  4  BCD ones digit or display code
- busy  output  1  high from the edge that accepts start until DONE is left
- done  output  1  one-cycle pulse; result valid
- binary  output  BIN_W  result; held from done until the next accepted start
- error  output  1  result invalid (bad digit, mixed code, or value > 2^BIN_W-1); held with binary
- special  output  1  result is a dash/blank sentinel; held with binary

Behaviour:
- Reset (synchronous, active-high): state IDLE, busy=0, done=0, binary=0, error=0, special=0, counter=0.
- Reset mid-operation aborts the conversion: no done pulse, outputs return to reset values.

FSM states:
- IDLE: on start=1, latch the three digits into a 12-bit BCD register. Clear the BIN_W-bit shift register, counter=0, busy=1, go to SHIFT.
- Classification at the accepting edge:
  - All digits = 1010 → special path with value 2^BIN_W-1.
  - All digits = 1011 → special path with value 2^BIN_W-2.
  - Any digit > 9 otherwise, including mixed codes → error path.
  - Otherwise → numeric path.
- SHIFT: each edge performs one reverse double-dabble step.
  - Shift the combined {bcd, bin} register right by 1.
  - Then subtract 3 from every BCD digit that is ≥ 8.
  - Counter increments each step; after BIN_W steps, go to DONE.
  - Special and error paths still spend BIN_W cycles in SHIFT, so latency is fixed.
- DONE: done=1 for exactly this cycle; busy drops on the exit edge; go to IDLE. binary/error/special are updated on the edge entering DONE:
  - Numeric path, BCD residual = 0: binary = shift register, error=0, special=0.
  - Numeric path, BCD residual ≠ 0 (overflow, e.g. 128..999 for BIN_W=7): binary=0, error=1, special=0.
  - Special path: binary = sentinel, special=1, error=0.
  - Error path: binary=0, error=1, special=0.

Timing and boundary rules:
- Latency: done is high in the cycle following edge k+BIN_W+1, where edge k sampled start. For BIN_W=7 that is 8 edges.
- start while busy (SHIFT or DONE) is ignored; it is not queued.
- start held high continuously: a new conversion is accepted in the IDLE cycle after DONE.
- Digit inputs are only sampled at the accepting edge; later changes have no effect.
- Numeric 126/127 convert normally with special=0. The special flag is what distinguishes them from the sentinels.

Arithmetic:
- Per-digit adjust is 4-bit: a digit ≥ 8 becomes digit-3, with no carry between digits.
- The residual check is an OR-reduction of the 12-bit BCD register after the final shift.

Decomposition:
- Package bcd_pkg:
  - DIGIT_DASH=4'b1010, DIGIT_BLANK=4'b1011.
  - Sentinel functions/constants for all-ones and all-ones-1 at BIN_W.
  - State enum {IDLE, SHIFT, DONE}.
  - Counter width $clog2(BIN_W+1).
- One natural sub-module: bcd_digit_adjust (combinational, 4-bit in/out, subtract 3 if ≥ 8), instantiated three times.

Test Plan:
- Digits 1,2,3, start pulse → after 8 edges done=1 for one cycle, binary=7'd123, error=0, special=0, busy low the cycle after.
- Digits 0,0,0 and then 1,2,7 → binary=0 then 127, special=0 both times; a start asserted during busy of the first is ignored.
- Digits 1,2,8 and 9,9,9 → done at fixed latency, binary=0, error=1 (overflow via nonzero residual).
- Digits 1010,1010,1010 → binary=7'h7F, special=1. Digits 1011,1011,1011 → binary=7'h7E, special=1. Digits 1010,0,1 → error=1, binary=0.
- Digit 1100 in the tens position → error=1, binary=0, latency unchanged at 8 edges.
- Reset asserted 3 cycles after start → no done pulse, all outputs 0. A start with digits 0,4,2 one cycle after reset releases → binary=42.
